// File: rtl/axp_pkg.sv
// axp_pkg: definitions shared by the AXP operand-fetch stage and its register
// file.
//   - opcodes of the two integer operate groups
//   - bit positions of the fields in an operate instruction word
//   - register-index type and the hardwired-zero register
package axp_pkg;

  localparam logic [5:0] AXP_OP_INTA = 6'h10;
  localparam logic [5:0] AXP_OP_INTL = 6'h11;

  localparam int OPC_HI   = 31;
  localparam int OPC_LO   = 26;
  localparam int RA_HI    = 25;
  localparam int RA_LO    = 21;
  localparam int RB_HI    = 20;
  localparam int RB_LO    = 16;
  localparam int LIT_HI   = 20;
  localparam int LIT_LO   = 13;
  localparam int LIT_FLAG = 12;
  localparam int RC_HI    = 4;
  localparam int RC_LO    = 0;

  typedef logic [4:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = 5'd31;
  localparam bit       R31_ZERO = 1'b1;

  function automatic logic is_operate(input logic [5:0] op);
    return (op == AXP_OP_INTA) || (op == AXP_OP_INTL);
  endfunction

endpackage

// File: rtl/axp_regfile.sv
// axp_regfile: 31 x 64-bit integer register file. R31 reads as zero, and
// writes to R31 are dropped.
//   clk, rst_n             : clock, async active-low reset (clears R0-R30)
//   rd_idx_{a,b,c}         : read addresses
//   rd_data_{a,b,c}        : read data; a same-cycle write to the address is
//                            forwarded (write-through)
//   wr_en, wr_idx, wr_data : single write port, updates on the rising edge
module axp_regfile
  import axp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rd_idx_a,
  input  logic [4:0]  rd_idx_b,
  input  logic [4:0]  rd_idx_c,
  output logic [63:0] rd_data_a,
  output logic [63:0] rd_data_b,
  output logic [63:0] rd_data_c,
  input  logic        wr_en,
  input  logic [4:0]  wr_idx,
  input  logic [63:0] wr_data
);

  logic [63:0] mem [0:30];

  function automatic logic [63:0] rd_port(input logic [4:0] idx);
    if (R31_ZERO && (idx == REG_ZERO)) return '0;
    else if (wr_en && (wr_idx == idx)) return wr_data;
    else return mem[idx];
  endfunction

  assign rd_data_a = rd_port(rd_idx_a);
  assign rd_data_b = rd_port(rd_idx_b);
  assign rd_data_c = rd_port(rd_idx_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 31; i++) mem[i] <= '0;
    end else if (wr_en && (wr_idx != REG_ZERO)) begin
      mem[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/axp_opfetch.sv
// axp_opfetch: operand fetch for AXP integer operate instructions.
// Reads Ra/Rb/Rc from the register file. Stalls while any source register has
// a write still outstanding (scoreboard), and hands {cmd,a,b,c} to the
// execute units through a one-entry valid/ready output register.
//   clk, rst_n                     : clock, async active-low reset
//   in_valid/in_ready/in_cmd       : decoded instruction input handshake
//   wb_en/wb_reg/wb_data           : result writeback from execute
//   out_valid/out_ready            : output bundle handshake
//   out_cmd/out_a/out_b/out_c      : instruction word and operands
//   out_illegal                    : opcode is not an integer operate
module axp_opfetch
  import axp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_cmd,
  input  logic        wb_en,
  input  logic [4:0]  wb_reg,
  input  logic [63:0] wb_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_cmd,
  output logic [63:0] out_a,
  output logic [63:0] out_b,
  output logic [63:0] out_c,
  output logic        out_illegal
);

  logic [4:0]  ra_idx, rb_idx, rc_idx, out_rc;
  logic        lit_sel;
  logic [63:0] rf_a, rf_b, rf_c, opnd_b;
  // Bit 31 exists only so the 5-bit index needs no range guard; it never sets.
  logic [31:0] pending, pending_nxt;
  logic        busy_a, busy_b, busy_c, hazard, accept, xfer;

  assign ra_idx  = in_cmd[RA_HI:RA_LO];
  assign rb_idx  = in_cmd[RB_HI:RB_LO];
  assign rc_idx  = in_cmd[RC_HI:RC_LO];
  assign lit_sel = in_cmd[LIT_FLAG];
  assign out_rc  = out_cmd[RC_HI:RC_LO];

  axp_regfile u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx_a  (ra_idx),
    .rd_idx_b  (rb_idx),
    .rd_idx_c  (rc_idx),
    .rd_data_a (rf_a),
    .rd_data_b (rf_b),
    .rd_data_c (rf_c),
    .wr_en     (wb_en),
    .wr_idx    (wb_reg),
    .wr_data   (wb_data)
  );

  // A pending source whose writeback lands this cycle is not a hazard: the
  // register file forwards wb_data to the read port.
  assign busy_a = (ra_idx != REG_ZERO) && pending[ra_idx] && !(wb_en && (wb_reg == ra_idx));
  assign busy_b = (rb_idx != REG_ZERO) && pending[rb_idx] && !(wb_en && (wb_reg == rb_idx));
  assign busy_c = (rc_idx != REG_ZERO) && pending[rc_idx] && !(wb_en && (wb_reg == rc_idx));

  // Rc is always checked: it supplies out_c, and waiting on it also keeps
  // writes to the same register in program order.
  assign hazard   = in_valid && (busy_a || (!lit_sel && busy_b) || busy_c);
  assign in_ready = !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid && out_ready;
  assign opnd_b   = lit_sel ? {56'b0, in_cmd[LIT_HI:LIT_LO]} : rf_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_cmd     <= '0;
      out_a       <= '0;
      out_b       <= '0;
      out_c       <= '0;
      out_illegal <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_cmd     <= in_cmd;
      out_a       <= rf_a;
      out_b       <= opnd_b;
      out_c       <= rf_c;
      out_illegal <= !is_operate(in_cmd[OPC_HI:OPC_LO]);
    end else if (xfer) begin
      out_valid   <= 1'b0;
    end
  end

  // Clear on writeback first, then set on transfer, so a same-cycle set wins:
  // the transferring instruction is the younger producer.
  always_comb begin
    pending_nxt = pending;
    if (wb_en) pending_nxt[wb_reg] = 1'b0;
    if (xfer && !out_illegal && (out_rc != REG_ZERO)) pending_nxt[out_rc] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pending_nxt;
  end

endmodule

// File: tb/tb_axp_opfetch.sv
module tb_axp_opfetch;
  import axp_pkg::*;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, wb_en = 1'b0, out_ready = 1'b0;
  logic [31:0] in_cmd = '0;
  logic [4:0]  wb_reg = '0;
  logic [63:0] wb_data = '0;
  logic        in_ready, out_valid, out_illegal;
  logic [31:0] out_cmd;
  logic [63:0] out_a, out_b, out_c;

  axp_opfetch dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_cmd(out_cmd), .out_a(out_a), .out_b(out_b),
    .out_c(out_c), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;

  // Reference model: architectural registers, outstanding-write set, and the
  // bundle the stage should currently be presenting.
  logic [63:0] m_regs [0:31];
  bit          m_pend [0:31];
  bit          m_valid, m_ill;
  logic [31:0] m_cmd;
  logic [63:0] m_a, m_b, m_c;

  function automatic logic [31:0] mk_reg(input logic [5:0] op, input int ra, input int rb, input int rc);
    return {op, 5'(ra), 5'(rb), 3'b000, 1'b0, 7'h20, 5'(rc)};
  endfunction

  function automatic logic [31:0] mk_lit(input logic [5:0] op, input int ra, input int lit, input int rc);
    return {op, 5'(ra), 8'(lit), 1'b1, 7'h20, 5'(rc)};
  endfunction

  function automatic logic [63:0] m_read(input logic [4:0] r);
    if (r == 5'd31) return '0;
    if (wb_en && wb_reg == r) return wb_data;
    return m_regs[r];
  endfunction

  function automatic bit m_busy(input logic [4:0] r);
    return (r != 5'd31) && m_pend[r] && !(wb_en && wb_reg == r);
  endfunction

  function automatic bit m_ready();
    bit haz;
    haz = m_busy(in_cmd[25:21]) || (!in_cmd[12] && m_busy(in_cmd[20:16])) || m_busy(in_cmd[4:0]);
    return !(in_valid && haz) && (!m_valid || out_ready);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin m_regs[i] = '0; m_pend[i] = 0; end
    m_valid = 0; m_ill = 0; m_cmd = '0; m_a = '0; m_b = '0; m_c = '0;
  endtask

  task automatic model_clock();
    bit acc, xfer;
    logic [63:0] a, b, c;
    if (!rst_n) begin model_reset(); return; end
    acc  = in_valid && m_ready();
    xfer = m_valid && out_ready;
    a = m_read(in_cmd[25:21]);
    b = in_cmd[12] ? {56'b0, in_cmd[20:13]} : m_read(in_cmd[20:16]);
    c = m_read(in_cmd[4:0]);
    if (wb_en) m_pend[wb_reg] = 0;
    if (wb_en && wb_reg != 5'd31) m_regs[wb_reg] = wb_data;
    if (xfer && !m_ill && m_cmd[4:0] != 5'd31) m_pend[m_cmd[4:0]] = 1;
    if (acc) begin
      m_valid = 1; m_cmd = in_cmd; m_a = a; m_b = b; m_c = c;
      m_ill = !(in_cmd[31:26] == 6'h10 || in_cmd[31:26] == 6'h11);
    end else if (xfer) m_valid = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 0; in_valid = 0; wb_en = 0; out_ready = 0;
    repeat (3) cyc();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (out_cmd !== 32'h0) begin n_err++; $display("FAIL reset_out_cmd got=%h exp=0", out_cmd); end
    n_cmp++; if ({out_a, out_b, out_c} !== 192'h0) begin n_err++; $display("FAIL reset_out_abc got=%h/%h/%h exp=0", out_a, out_b, out_c); end
    n_cmp++; if (out_illegal !== 1'b0) begin n_err++; $display("FAIL reset_out_illegal got=%b exp=0", out_illegal); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    rst_n = 1;
    cyc();
  endtask

  task automatic test_write_read();
    out_ready = 1; wb_en = 1; wb_reg = 1; wb_data = 64'd5;
    cyc();
    wb_en = 0; in_valid = 1; in_cmd = mk_lit(6'h10, 1, 3, 2);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL wr_in_ready got=%b exp=1", in_ready); end
    cyc();
    in_valid = 0;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL wr_out_valid got=%b exp=1", out_valid); end
    n_cmp++; if (out_a !== 64'd5 || out_b !== 64'd3 || out_c !== 64'd0)
      begin n_err++; $display("FAIL wr_operands got=%h/%h/%h exp=5/3/0", out_a, out_b, out_c); end
    cyc();
  endtask

  task automatic test_raw_stall();
    wb_en = 1; wb_reg = 2; wb_data = 64'h0;
    in_valid = 1; in_cmd = mk_reg(6'h10, 1, 1, 2);
    cyc();
    wb_en = 0; in_valid = 0;
    cyc();
    in_valid = 1; in_cmd = mk_reg(6'h10, 2, 3, 4);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL raw_stall_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
      cyc();
    end
    wb_en = 1; wb_reg = 2; wb_data = 64'h1234;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL raw_bypass_in_ready got=%b exp=1", in_ready); end
    cyc();
    wb_en = 0; in_valid = 0;
    n_cmp++; if (out_a !== 64'h1234) begin n_err++; $display("FAIL raw_bypass_out_a got=%h exp=1234", out_a); end
  endtask

  task automatic test_collision();
    out_ready = 1;
    cyc();
    in_valid = 1; in_cmd = mk_lit(6'h10, 0, 1, 4); wb_en = 1; wb_reg = 4; wb_data = 64'h55;
    cyc();
    wb_en = 0; in_cmd = mk_lit(6'h10, 0, 2, 4);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL coll_second_in_ready got=%b exp=1", in_ready); end
    cyc();
    in_valid = 0; wb_en = 1; wb_reg = 4; wb_data = 64'h77;
    cyc();
    wb_en = 0; in_valid = 1; in_cmd = mk_lit(6'h10, 4, 0, 6);
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL coll_reader_stall cyc=%0d got=%b exp=0", i, in_ready); end
      cyc();
    end
    wb_en = 1; wb_reg = 4; wb_data = 64'h99;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL coll_release got=%b exp=1", in_ready); end
    cyc();
    wb_en = 0; in_valid = 0;
    n_cmp++; if (out_a !== 64'h99) begin n_err++; $display("FAIL coll_out_a got=%h exp=99", out_a); end
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    held = mk_lit(6'h10, 4, 0, 6);
    out_ready = 0; in_valid = 1; in_cmd = mk_lit(6'h10, 0, 9, 7);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
      cyc();
      n_cmp++; if (out_valid !== 1'b1 || out_cmd !== held || out_a !== 64'h99)
        begin n_err++; $display("FAIL bp_hold cyc=%0d got=%b/%h/%h exp=1/%h/99", i, out_valid, out_cmd, out_a, held); end
    end
    out_ready = 1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); end
    cyc();
    in_valid = 0;
    n_cmp++; if (out_cmd !== mk_lit(6'h10, 0, 9, 7) || out_b !== 64'd9)
      begin n_err++; $display("FAIL bp_next got=%h/%h exp=%h/9", out_cmd, out_b, mk_lit(6'h10, 0, 9, 7)); end
  endtask

  task automatic test_r31_illegal();
    wb_en = 1; wb_reg = 31; wb_data = 64'hFF;
    cyc();
    wb_en = 0; in_valid = 1; in_cmd = mk_reg(6'h12, 31, 31, 8);
    cyc();
    in_valid = 0;
    n_cmp++; if (out_illegal !== 1'b1) begin n_err++; $display("FAIL ill_flag got=%b exp=1", out_illegal); end
    n_cmp++; if (out_a !== 64'h0 || out_b !== 64'h0) begin n_err++; $display("FAIL r31_read got=%h/%h exp=0/0", out_a, out_b); end
    cyc();
    in_valid = 1; in_cmd = mk_reg(6'h11, 8, 31, 9);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL ill_no_pending got=%b exp=1", in_ready); end
    cyc();
    in_valid = 0;
    n_cmp++; if (out_illegal !== 1'b0 || out_a !== 64'h0) begin n_err++; $display("FAIL legal_after_ill got=%b/%h exp=0/0", out_illegal, out_a); end
  endtask

  task automatic test_async_reset();
    in_valid = 1; in_cmd = mk_lit(6'h10, 0, 1, 5);
    cyc();
    in_valid = 0;
    cyc();
    in_valid = 1; in_cmd = mk_lit(6'h10, 1, 0, 11);
    cyc();
    in_valid = 0; out_ready = 0;
    #2 rst_n = 0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || out_cmd !== 32'h0 || out_a !== 64'h0)
      begin n_err++; $display("FAIL areset_immediate got=%b/%h/%h exp=0/0/0", out_valid, out_cmd, out_a); end
    model_reset();
    cyc();
    rst_n = 1;
    in_valid = 1; out_ready = 1; in_cmd = mk_reg(6'h10, 5, 1, 12);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL areset_r5_ready got=%b exp=1", in_ready); end
    cyc();
    in_valid = 0;
    n_cmp++; if (out_a !== 64'h0 || out_b !== 64'h0) begin n_err++; $display("FAIL areset_regs got=%h/%h exp=0/0", out_a, out_b); end
  endtask

  function automatic int rnd_reg();
    int r;
    r = $urandom_range(0, 7);
    return (r == 7) ? 31 : r;
  endfunction

  task automatic test_random();
    logic [5:0] op;
    for (int n = 0; n < 1500; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      wb_en     = ($urandom_range(0, 2) == 0);
      wb_reg    = 5'(rnd_reg());
      wb_data   = {$urandom, $urandom};
      op = ($urandom_range(0, 9) == 0) ? 6'h12 : ($urandom_range(0, 1) ? 6'h10 : 6'h11);
      in_cmd = $urandom_range(0, 1) ? mk_lit(op, rnd_reg(), $urandom_range(0, 255), rnd_reg())
                                    : mk_reg(op, rnd_reg(), rnd_reg(), rnd_reg());
      #1;
      n_cmp++; if (in_ready !== m_ready()) begin n_err++; $display("FAIL rnd_in_ready n=%0d got=%b exp=%b", n, in_ready, m_ready()); end
      cyc();
      n_cmp++; if (out_valid !== m_valid || out_cmd !== m_cmd || out_illegal !== m_ill)
        begin n_err++; $display("FAIL rnd_ctl n=%0d got=%b/%h/%b exp=%b/%h/%b", n, out_valid, out_cmd, out_illegal, m_valid, m_cmd, m_ill); end
      n_cmp++; if (out_a !== m_a || out_b !== m_b || out_c !== m_c)
        begin n_err++; $display("FAIL rnd_operands n=%0d got=%h/%h/%h exp=%h/%h/%h", n, out_a, out_b, out_c, m_a, m_b, m_c); end
    end
    in_valid = 0; wb_en = 0;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_raw_stall();
    test_collision();
    test_backpressure();
    test_r31_illegal();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
